// File: rtl/calc_queue.sv
// Operand queue for the queue calculator: circular FIFO of 8-bit entries driven by ALU queue commands.
// Latency: a command is accepted and committed at one edge; sync, q_err and err_code follow one cycle later, and operands reads the new head combinationally.
// Backpressure: op_ready is high in RUN and low in HALT; HALT is left with err_clr (or flush when CALC_QUEUE_FLUSH_EN is defined).
module calc_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [1:0]                 i_queue_op,
    input  logic                       i_op_valid,
    output logic                       o_op_ready,
    input  logic [7:0]                 i_data_in,
    input  logic                       i_calc_err,
    input  logic                       i_err_clr,
`ifdef CALC_QUEUE_FLUSH_EN
    input  logic                       i_flush,
`endif
    output logic [15:0]                o_operands,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_sync,
    output logic                       o_q_err,
    output logic [1:0]                 o_err_code
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] Q_PUSH         = 2'b00;
    localparam logic [1:0] Q_SLEEP        = 2'b01;
    localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;
    localparam logic [1:0] Q_POP          = 2'b11;

    localparam logic [1:0] E_NONE      = 2'b00;
    localparam logic [1:0] E_UNDERFLOW = 2'b01;
    localparam logic [1:0] E_OVERFLOW  = 2'b10;
    localparam logic [1:0] E_CALC      = 2'b11;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t          r_state;
    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_sync;
    logic [1:0]      r_err_code;

    logic            w_flush;
    logic            w_accept;
    logic            w_full;
    logic            w_err_calc;
    logic            w_err_ovf;
    logic            w_err_udf;
    logic            w_exec;
    logic            w_wr;
    logic [PW-1:0]   w_next_ptr;

`ifdef CALC_QUEUE_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    // Decode an accepted command into its error class or a legal execution.
    always_comb begin
        w_accept   = 1'b0;
        w_err_calc = 1'b0;
        w_err_ovf  = 1'b0;
        w_err_udf  = 1'b0;
        w_exec     = 1'b0;
        w_wr       = 1'b0;
        w_full     = (r_count == CW'(DEPTH));
        // A flush in the same cycle swallows the command entirely.
        w_accept   = i_op_valid && (r_state == S_RUN) && !w_flush;
        if (w_accept) begin
            if (i_calc_err) begin
                w_err_calc = 1'b1;
            end else if ((i_queue_op == Q_PUSH) && w_full) begin
                w_err_ovf = 1'b1;
            end else if (((i_queue_op == Q_POP) && (r_count == '0)) ||
                         ((i_queue_op == Q_GET_AND_PUSH) && (r_count < CW'(2)))) begin
                w_err_udf = 1'b1;
            end else begin
                w_exec = 1'b1;
            end
        end
        // GET_AND_PUSH is legal when full: the slot at tail equals head and is consumed.
        w_wr = w_exec && ((i_queue_op == Q_PUSH) || (i_queue_op == Q_GET_AND_PUSH));
    end

    // Storage write; contents survive reset and HALT and are only gated by legal pushes.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_tail] <= i_data_in;
        end
    end

    // RUN/HALT state machine with pointer, occupancy, sync and error-code registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= S_RUN;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_sync     <= 1'b0;
            r_err_code <= E_NONE;
        end else begin
            r_sync <= 1'b0;
            if (w_flush) begin
                r_state    <= S_RUN;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_err_code <= E_NONE;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (w_err_calc) begin
                            r_state    <= S_HALT;
                            r_err_code <= E_CALC;
                        end else if (w_err_ovf) begin
                            r_state    <= S_HALT;
                            r_err_code <= E_OVERFLOW;
                        end else if (w_err_udf) begin
                            r_state    <= S_HALT;
                            r_err_code <= E_UNDERFLOW;
                        end else if (w_exec) begin
                            r_sync <= 1'b1;
                            case (i_queue_op)
                                Q_PUSH: begin
                                    r_tail  <= r_tail + PW'(1);
                                    r_count <= r_count + CW'(1);
                                end
                                Q_POP: begin
                                    r_head  <= r_head + PW'(1);
                                    r_count <= r_count - CW'(1);
                                end
                                Q_GET_AND_PUSH: begin
                                    r_head  <= r_head + PW'(2);
                                    r_tail  <= r_tail + PW'(1);
                                    r_count <= r_count - CW'(1);
                                end
                                default: begin
                                    // Q_SLEEP: completes without touching the queue.
                                end
                            endcase
                        end
                    end
                    S_HALT: begin
                        if (i_err_clr) begin
                            r_state    <= S_RUN;
                            r_err_code <= E_NONE;
                        end
                    end
                    default: begin
                        r_state <= S_RUN;
                    end
                endcase
            end
        end
    end

    // Operand word: head entry in the low byte, next entry in the high byte, zero when absent.
    always_comb begin
        w_next_ptr = r_head + PW'(1);
        o_operands = 16'h0000;
        if (r_count >= CW'(1)) begin
            o_operands[7:0] = r_mem[r_head];
        end
        if (r_count >= CW'(2)) begin
            o_operands[15:8] = r_mem[w_next_ptr];
        end
    end

    assign o_op_ready = (r_state == S_RUN);
    assign o_q_err    = (r_state == S_HALT);
    assign o_err_code = r_err_code;
    assign o_sync     = r_sync;
    assign o_count    = r_count;
    assign o_empty    = (r_count == '0);
    assign o_full     = w_full;

endmodule

// File: tb/tb_calc_queue.sv
// Directed bench for calc_queue: linear command sequence with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the edge that committed them.
// Optional flush port is exercised only when CALC_QUEUE_FLUSH_EN is defined.
module tb_calc_queue;

    localparam logic [1:0] Q_PUSH  = 2'b00;
    localparam logic [1:0] Q_SLEEP = 2'b01;
    localparam logic [1:0] Q_GAP   = 2'b10;
    localparam logic [1:0] Q_POP   = 2'b11;

    logic        clk;
    logic        rst;
    logic [1:0]  queue_op;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  data_in;
    logic        calc_err;
    logic        err_clr;
    logic [15:0] operands;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        sync;
    logic        q_err;
    logic [1:0]  err_code;
`ifdef CALC_QUEUE_FLUSH_EN
    logic        flush;
`endif

    int total = 0;
    int bad   = 0;

    calc_queue #(.DEPTH(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_queue_op (queue_op),
        .i_op_valid (op_valid),
        .o_op_ready (op_ready),
        .i_data_in  (data_in),
        .i_calc_err (calc_err),
        .i_err_clr  (err_clr),
`ifdef CALC_QUEUE_FLUSH_EN
        .i_flush    (flush),
`endif
        .o_operands (operands),
        .o_count    (count),
        .o_empty    (empty),
        .o_full     (full),
        .o_sync     (sync),
        .o_q_err    (q_err),
        .o_err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command presented for exactly one rising edge, then sampled 1 ns later.
    task automatic cmd(input logic [1:0] op, input logic [7:0] d, input logic ce);
        queue_op = op;
        data_in  = d;
        calc_err = ce;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        calc_err = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        queue_op = Q_SLEEP;
        op_valid = 1'b0;
        data_in  = 8'h00;
        calc_err = 1'b0;
        err_clr  = 1'b0;
`ifdef CALC_QUEUE_FLUSH_EN
        flush    = 1'b0;
`endif
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_operands", 32'(operands), 32'h0);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_sync", 32'(sync), 32'd0);
        chk("rst_qerr", 32'(q_err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 5 + 3 = 8
        cmd(Q_PUSH, 8'h05, 1'b0);
        chk("p5_count", 32'(count), 32'd1);
        chk("p5_sync", 32'(sync), 32'd1);
        chk("p5_ops", 32'(operands), 32'h0005);
        cmd(Q_PUSH, 8'h03, 1'b0);
        chk("p3_count", 32'(count), 32'd2);
        chk("p3_sync", 32'(sync), 32'd1);
        chk("p3_ops", 32'(operands), 32'h0305);
        cmd(Q_GAP, 8'h08, 1'b0);
        chk("add_count", 32'(count), 32'd1);
        chk("add_sync", 32'(sync), 32'd1);
        chk("add_ops", 32'(operands), 32'h0008);
        idle();
        chk("idle_sync", 32'(sync), 32'd0);
        cmd(Q_SLEEP, 8'h00, 1'b0);
        chk("sleep_sync", 32'(sync), 32'd1);
        chk("sleep_count", 32'(count), 32'd1);
        cmd(Q_POP, 8'h00, 1'b0);
        chk("pop_empty", 32'(empty), 32'd1);

        // 0x10 - 0x02 = 0x0E
        cmd(Q_PUSH, 8'h10, 1'b0);
        cmd(Q_PUSH, 8'h02, 1'b0);
        chk("sub_ops", 32'(operands), 32'h0210);
        cmd(Q_GAP, 8'h0E, 1'b0);
        chk("sub_res", 32'(operands[7:0]), 32'h0E);
        chk("sub_count", 32'(count), 32'd1);
        cmd(Q_POP, 8'h00, 1'b0);

        // Underflow
        cmd(Q_POP, 8'h00, 1'b0);
        chk("udf_qerr", 32'(q_err), 32'd1);
        chk("udf_code", 32'(err_code), 32'd1);
        chk("udf_ready", 32'(op_ready), 32'd0);
        chk("udf_sync", 32'(sync), 32'd0);
        clear_err();
        chk("clr_qerr", 32'(q_err), 32'd0);
        chk("clr_code", 32'(err_code), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_ready", 32'(op_ready), 32'd1);

        // Fill, then overflow
        for (int i = 1; i <= 8; i++) cmd(Q_PUSH, 8'(i), 1'b0);
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_full", 32'(full), 32'd1);
        cmd(Q_PUSH, 8'hAA, 1'b0);
        chk("ovf_code", 32'(err_code), 32'd2);
        chk("ovf_count", 32'(count), 32'd8);
        chk("ovf_sync", 32'(sync), 32'd0);
        clear_err();
        cmd(Q_GAP, 8'h99, 1'b0);
        chk("gapfull_count", 32'(count), 32'd7);
        chk("gapfull_qerr", 32'(q_err), 32'd0);
        chk("gapfull_sync", 32'(sync), 32'd1);
        chk("gapfull_ops", 32'(operands), 32'h0403);
        // Remaining order: 3,4,5,6,7,8,0x99
        for (int i = 3; i <= 8; i++) begin
            chk("drain_head", 32'(operands[7:0]), 32'(i));
            cmd(Q_POP, 8'h00, 1'b0);
        end
        chk("drain_last", 32'(operands), 32'h0099);
        cmd(Q_POP, 8'h00, 1'b0);
        chk("drain_empty", 32'(count), 32'd0);

        // Pointer wrap: 20 push/pop pairs with a resident entry keeping FIFO order visible
        cmd(Q_PUSH, 8'hC0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cmd(Q_PUSH, 8'(8'hC1 + i), 1'b0);
            chk("wrap_ops", 32'(operands), 32'({8'(8'hC1 + i), 8'(8'hC0 + i)}));
            cmd(Q_POP, 8'h00, 1'b0);
        end
        chk("wrap_count", 32'(count), 32'd1);
        cmd(Q_POP, 8'h00, 1'b0);

        // Calculation error on an accepted DIV
        cmd(Q_PUSH, 8'h20, 1'b0);
        cmd(Q_PUSH, 8'h30, 1'b0);
        cmd(Q_GAP, 8'h55, 1'b1);
        chk("calc_code", 32'(err_code), 32'd3);
        chk("calc_count", 32'(count), 32'd2);
        chk("calc_ops", 32'(operands), 32'h3020);
        chk("calc_sync", 32'(sync), 32'd0);
        // Command alongside err_clr in HALT is not accepted
        err_clr = 1'b1;
        cmd(Q_PUSH, 8'h77, 1'b0);
        err_clr = 1'b0;
        chk("halt_cmd_count", 32'(count), 32'd2);
        chk("halt_cmd_sync", 32'(sync), 32'd0);
        chk("halt_cmd_run", 32'(q_err), 32'd0);

        // Reset in the middle of HALT with four entries
        cmd(Q_PUSH, 8'h40, 1'b0);
        cmd(Q_PUSH, 8'h50, 1'b0);
        cmd(Q_SLEEP, 8'h00, 1'b1);
        chk("pre_rst_count", 32'(count), 32'd4);
        chk("pre_rst_qerr", 32'(q_err), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_ops", 32'(operands), 32'h0);
        chk("mid_rst_qerr", 32'(q_err), 32'd0);
        chk("mid_rst_code", 32'(err_code), 32'd0);
        chk("mid_rst_ready", 32'(op_ready), 32'd1);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_sync", 32'(sync), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef CALC_QUEUE_FLUSH_EN
        cmd(Q_PUSH, 8'h01, 1'b0);
        cmd(Q_PUSH, 8'h02, 1'b0);
        cmd(Q_PUSH, 8'h03, 1'b0);
        flush = 1'b1;
        cmd(Q_PUSH, 8'h04, 1'b0);
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_sync", 32'(sync), 32'd0);
        chk("flush_ops", 32'(operands), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
